// File: rtl/launcher_pkg.sv
// Shared types and constants for the launcher power-stage ADC path.
package launcher_pkg;

    localparam int unsigned ADC_BITS    = 12;
    localparam int unsigned CONV_CYCLES = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } adc_state_t;

    typedef struct packed {
        logic [ADC_BITS-1:0] vcap;
        logic [ADC_BITS-1:0] icap;
        logic [ADC_BITS-1:0] vout;
        logic [ADC_BITS-1:0] iout;
    } adc_sample_t;

endpackage

// File: rtl/ad7352_sequencer_if.sv
// ADC pin and sample-word bundle between the AD7352 sequencer and its neighbours.
interface ad7352_sequencer_if;
    import launcher_pkg::*;

    logic                enable;
    logic                ad_cs;
    logic [1:0]          ad_sdata_a;
    logic [1:0]          ad_sdata_b;
    logic [ADC_BITS-1:0] vcap;
    logic [ADC_BITS-1:0] icap;
    logic [ADC_BITS-1:0] vout;
    logic [ADC_BITS-1:0] iout;
    logic                sample_valid;
    logic                busy;

    modport master (
        input  enable, ad_sdata_a, ad_sdata_b,
        output ad_cs, vcap, icap, vout, iout, sample_valid, busy
    );

    modport slave (
        output enable, ad_sdata_a, ad_sdata_b,
        input  ad_cs, vcap, icap, vout, iout, sample_valid, busy
    );

endinterface

// File: rtl/adc_lane_deser.sv
// One serial ADC lane: MSB-first shift register with a shift enable.
module adc_lane_deser
    import launcher_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                shift_en,
    input  logic                din,
    output logic [ADC_BITS-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[ADC_BITS-2:0], din};
        end
    end

endmodule

// File: rtl/ad7352_sequencer.sv
// Free-running dual AD7352 conversion controller: drives ad_cs, deserializes
// four 12-bit lanes and publishes them together with a one-cycle valid strobe.
module ad7352_sequencer
    import launcher_pkg::*;
#(
    parameter int unsigned CONV_PERIOD  = 16,
    parameter int unsigned QUIET_CYCLES = 2
)(
    input  logic                clk,
    input  logic                reset,
    ad7352_sequencer_if.master  bus
);

    // Short periods are stretched so CONV plus at least one quiet cycle always fits.
    localparam int unsigned QUIET_MIN  = (QUIET_CYCLES < 1) ? 1 : QUIET_CYCLES;
    localparam int unsigned MIN_PERIOD = CONV_CYCLES + QUIET_MIN;
    localparam int unsigned EFF_PERIOD = (CONV_PERIOD > MIN_PERIOD) ? CONV_PERIOD : MIN_PERIOD;
    localparam int unsigned CNT_W      = $clog2(EFF_PERIOD);

    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(EFF_PERIOD - 1);
    localparam logic [CNT_W-1:0] SHIFT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(ADC_BITS);

    adc_state_t          state;
    logic [CNT_W-1:0]    cnt;
    adc_sample_t         sample;
    logic                shift_en;
    logic [ADC_BITS-1:0] q_vcap;
    logic [ADC_BITS-1:0] q_icap;
    logic [ADC_BITS-1:0] q_vout;
    logic [ADC_BITS-1:0] q_iout;

    // Leading zero arrives at cnt 0; data bits 11..0 are on the lanes for cnt 1..12.
    assign shift_en = (state == CONV) && (cnt >= SHIFT_FIRST) && (cnt <= SHIFT_LAST);

    adc_lane_deser u_lane_vout (.clk(clk), .reset(reset), .shift_en(shift_en), .din(bus.ad_sdata_a[1]), .q(q_vout));
    adc_lane_deser u_lane_iout (.clk(clk), .reset(reset), .shift_en(shift_en), .din(bus.ad_sdata_a[0]), .q(q_iout));
    adc_lane_deser u_lane_vcap (.clk(clk), .reset(reset), .shift_en(shift_en), .din(bus.ad_sdata_b[1]), .q(q_vcap));
    adc_lane_deser u_lane_icap (.clk(clk), .reset(reset), .shift_en(shift_en), .din(bus.ad_sdata_b[0]), .q(q_icap));

    // cnt counts from the CONV entry edge through the whole period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.ad_cs        <= 1'b1;
            sample           <= '0;
            bus.sample_valid <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state     <= CONV;
                        cnt       <= '0;
                        bus.ad_cs <= 1'b0;
                        bus.busy  <= 1'b1;
                    end
                end
                CONV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CONV_LAST) begin
                        state            <= QUIET;
                        bus.ad_cs        <= 1'b1;
                        sample           <= '{vcap: q_vcap, icap: q_icap, vout: q_vout, iout: q_iout};
                        bus.sample_valid <= 1'b1;
                    end
                end
                QUIET: begin
                    if (cnt == PERIOD_LAST) begin
                        cnt <= '0;
                        if (bus.enable) begin
                            state     <= CONV;
                            bus.ad_cs <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bus.ad_cs <= 1'b1;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vcap = sample.vcap;
    assign bus.icap = sample.icap;
    assign bus.vout = sample.vout;
    assign bus.iout = sample.iout;

endmodule

// File: tb/tb_ad7352_sequencer.sv
// Randomized bench for ad7352_sequencer: behavioural AD7352 lane model plus
// frame scoreboard, directed scenarios, and a short-period instance.
module tb_ad7352_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad7352_sequencer_if ifc ();
    ad7352_sequencer_if ifc2 ();

    ad7352_sequencer #(.CONV_PERIOD(16), .QUIET_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .bus(ifc.master)
    );

    ad7352_sequencer #(.CONV_PERIOD(10), .QUIET_CYCLES(2)) dut10 (
        .clk(clk), .reset(reset2), .bus(ifc2.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---- AD7352 model and scoreboard ----
    logic [47:0] exp_q[$];
    int          t0_q[$];
    logic        fixed_words = 1'b0;
    logic [47:0] fixed_frame;
    logic [47:0] frame;
    int          adc_k = -1;
    logic        prev_cs = 1'b1;
    logic        had_frame = 1'b0;
    int          low_run = 0;
    int          high_run = 0;
    logic        cont_mode = 1'b0;
    int          last_valid = -1;

    always @(negedge clk) begin
        logic [47:0] e;
        int          t;
        int          idx;
        if (reset) begin
            exp_q.delete();
            t0_q.delete();
            had_frame = 1'b0;
            low_run   = 0;
            high_run  = 0;
        end else begin
            if (!ifc.ad_cs && prev_cs) begin
                if (had_frame) chk("cs_high_run_min2", 64'(high_run >= 2), 64'd1);
                low_run = 0;
            end
            if (ifc.ad_cs && !prev_cs) begin
                chk("cs_low_run", 64'(low_run), 64'd14);
                high_run  = 0;
                had_frame = 1'b1;
            end
            if (!ifc.ad_cs) low_run++;
            else            high_run++;
        end

        if (ifc.sample_valid) begin
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                t = t0_q.pop_front();
                chk("sample_words", {16'd0, ifc.vcap, ifc.icap, ifc.vout, ifc.iout}, {16'd0, e});
                chk("valid_latency", 64'(cyc - t), 64'd14);
            end
            if (cont_mode) begin
                if (last_valid >= 0) chk("valid_spacing", 64'(cyc - last_valid), 64'd16);
                last_valid = cyc;
            end
        end

        // Lanes are garbage while ad_cs is high; frame = 0, bits 11..0, then 0.
        if (ifc.ad_cs) begin
            adc_k = -1;
            ifc.ad_sdata_a = 2'($urandom);
            ifc.ad_sdata_b = 2'($urandom);
        end else begin
            if (adc_k < 0) begin
                frame = fixed_words ? fixed_frame : 48'({$urandom(), $urandom()});
                exp_q.push_back(frame);
                t0_q.push_back(cyc);
                adc_k = 0;
            end else begin
                adc_k++;
            end
            if (adc_k >= 1 && adc_k <= 12) begin
                idx = 12 - adc_k;
                ifc.ad_sdata_a = {frame[12 + idx], frame[idx]};
                ifc.ad_sdata_b = {frame[36 + idx], frame[24 + idx]};
            end else begin
                ifc.ad_sdata_a = 2'b00;
                ifc.ad_sdata_b = 2'b00;
            end
        end
        prev_cs = ifc.ad_cs;
    end

    // ---- short-period instance: timing only ----
    logic prev_cs2 = 1'b1;
    int   last_fall2 = -1;
    int   last_valid2 = -1;
    int   high_run2 = 0;

    always @(negedge clk) begin
        ifc2.ad_sdata_a = 2'($urandom);
        ifc2.ad_sdata_b = 2'($urandom);
        if (!reset2) begin
            if (!ifc2.ad_cs && prev_cs2) begin
                if (last_fall2 >= 0) begin
                    chk("p10_period", 64'(cyc - last_fall2), 64'd16);
                    chk("p10_high_min2", 64'(high_run2 >= 2), 64'd1);
                end
                last_fall2 = cyc;
            end
            if (ifc2.ad_cs && !prev_cs2) high_run2 = 0;
            if (ifc2.ad_cs) high_run2++;
            if (ifc2.sample_valid) begin
                if (last_valid2 >= 0) chk("p10_valid_spacing", 64'(cyc - last_valid2), 64'd16);
                last_valid2 = cyc;
            end
        end
        prev_cs2 = ifc2.ad_cs;
    end

    // ---- stimulus helpers (all act at negedge + 1) ----
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        do begin step(); n++; end while (ifc.ad_cs && n < 40);
        if (ifc.ad_cs) chk({tag, "_cs_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin step(); n++; end while (!ifc.sample_valid && n < 40);
        if (!ifc.sample_valid) chk({tag, "_valid_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin step(); n++; end while (ifc.busy && n < 40);
        if (ifc.busy) chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int t0;
        int nvalid;
        reset       = 1'b1;
        reset2      = 1'b1;
        ifc.enable  = 1'b1;
        ifc2.enable = 1'b1;
        fixed_frame = {12'(320 * 8), 12'(0 * 256), 12'(20 * 8), 12'(2 * 256)};

        // Reset held with enable high
        repeat (5) begin
            step();
            chk("rst_cs", 64'(ifc.ad_cs), 64'd1);
            chk("rst_valid", 64'(ifc.sample_valid), 64'd0);
            chk("rst_busy", 64'(ifc.busy), 64'd0);
            chk("rst_words", {16'd0, ifc.vcap, ifc.icap, ifc.vout, ifc.iout}, 64'd0);
        end
        reset2 = 1'b0;

        // Single directed conversion; earliest ad_cs fall is the first posedge after reset
        fixed_words = 1'b1;
        reset = 1'b0;
        step();
        chk("first_cs_fall", 64'(ifc.ad_cs), 64'd0);
        chk("first_busy", 64'(ifc.busy), 64'd1);
        ifc.enable = 1'b0;
        wait_valid("single");
        chk("single_vcap", 64'(ifc.vcap), 64'h0A00);
        chk("single_icap", 64'(ifc.icap), 64'h0000);
        chk("single_vout", 64'(ifc.vout), 64'h00A0);
        chk("single_iout", 64'(ifc.iout), 64'h0200);
        step();
        chk("single_valid_one_cycle", 64'(ifc.sample_valid), 64'd0);
        wait_idle("single");
        fixed_words = 1'b0;

        // Continuous run, random words
        cont_mode  = 1'b1;
        last_valid = -1;
        nvalid     = 0;
        ifc.enable = 1'b1;
        repeat (1000) begin
            step();
            if (ifc.sample_valid) nvalid++;
        end
        chk("cont_valid_count_62_63", 64'(nvalid == 62 || nvalid == 63), 64'd1);
        ifc.enable = 1'b0;
        wait_idle("cont");
        cont_mode = 1'b0;

        // enable dropped at t0+5
        ifc.enable = 1'b1;
        wait_cs_low("drop");
        t0 = cyc;
        while (cyc < t0 + 4) step();
        ifc.enable = 1'b0;
        while (cyc < t0 + 22) begin
            step();
            if (cyc == t0 + 14) chk("drop_valid", 64'(ifc.sample_valid), 64'd1);
            if (cyc == t0 + 15) chk("drop_busy_quiet", 64'(ifc.busy), 64'd1);
            if (cyc == t0 + 16) chk("drop_busy_clear", 64'(ifc.busy), 64'd0);
            if (cyc >= t0 + 14) chk("drop_cs_high", 64'(ifc.ad_cs), 64'd1);
        end

        // reset pulsed at t0+7
        ifc.enable = 1'b1;
        wait_cs_low("rstmid");
        t0 = cyc;
        while (cyc < t0 + 7) step();
        reset      = 1'b1;
        ifc.enable = 1'b0;
        #1;
        chk("rstmid_cs_immediate", 64'(ifc.ad_cs), 64'd1);
        chk("rstmid_busy", 64'(ifc.busy), 64'd0);
        chk("rstmid_words", {16'd0, ifc.vcap, ifc.icap, ifc.vout, ifc.iout}, 64'd0);
        step();
        reset  = 1'b0;
        nvalid = 0;
        repeat (30) begin
            step();
            if (ifc.sample_valid) nvalid++;
        end
        chk("rstmid_no_valid", 64'(nvalid), 64'd0);
        ifc.enable = 1'b1;
        wait_cs_low("rearm");
        ifc.enable = 1'b0;
        wait_valid("rearm");
        wait_idle("rearm");
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad7352_sequencer.md
# ad7352_sequencer

Free-running conversion controller for the dual AD7352 front end of the launcher power stage. It drives the shared active-low chip select, deserializes the four 2-bit-lane serial streams into 12-bit capacitor voltage, capacitor current, output voltage and output current samples, and presents them as registered words with a one-cycle valid strobe. It sits between the A/D pins and the PWM/current loop inside `blaster`. The ADC serial clock is the system clock: the ADC launches data on the falling edge, and this block captures on the rising edge.

## Interface
Parameters:
- `CONV_PERIOD`, 16: clk cycles between successive `ad_cs` falling edges; gives 3 MSPS at 48 MHz.
- `QUIET_CYCLES`, 2: minimum `ad_cs` high time between conversions.

Ports:
- `clk` in 1: system clock, 48 MHz; also the ADC SCLK.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run conversions while high.
- `ad_cs` out 1: ADC chip select, active low.
- `ad_sdata_a` in 2: bit 1 is vout, bit 0 is iout.
- `ad_sdata_b` in 2: bit 1 is vcap, bit 0 is icap.
- `vcap` out 12: capacitor voltage, 8 LSB/V.
- `icap` out 12: capacitor current, 256 LSB/A.
- `vout` out 12: output voltage, 8 LSB/V.
- `iout` out 12: output (coil) current, 256 LSB/A.
- `sample_valid` out 1: one-cycle pulse when all four words update together.
- `busy` out 1: high while in CONV or QUIET.

## Operation
- Reset values (applied asynchronously):
  - `ad_cs` = 1.
  - `vcap`/`icap`/`vout`/`iout` = 0.
  - `sample_valid` = 0, `busy` = 0.
  - state = IDLE; counters = 0.
- States:
  - IDLE: `ad_cs` = 1. If `enable` = 1 at a posedge, go to CONV.
  - CONV: exactly 14 cycles with `ad_cs` = 0. The cycle counter `cnt` runs 0..13.
  - QUIET: `ad_cs` = 1. Stay until `CONV_PERIOD` cycles have elapsed since the CONV entry edge, then:
    - go to CONV if `enable` = 1;
    - go to IDLE otherwise.
- Effective period = max(`CONV_PERIOD`, 14 + `QUIET_CYCLES`). Smaller settings are clamped, never violated.
- Frame format: the ADC drives one leading zero, then bits 11..0 MSB first, then zero.
  - Lane shift registers shift left while `cnt` is in 1..12, so 12 bits are captured per lane.
  - Lane data is captured directly, with no input synchronizer, because it is the same clock.
- Deassert of `enable` mid-conversion: the current conversion completes, is delivered with `sample_valid`, then the block goes through QUIET to IDLE. There are no partial frames.
- Reset mid-conversion: `ad_cs` returns high immediately and no sample is delivered. The ADC reframes on the next falling edge of `ad_cs`.
- Lane data while `ad_cs` = 1 is X on the board and is ignored; shift registers are not enabled.

## Timing
- Define t0 as the posedge on which IDLE/QUIET moves to CONV. `ad_cs` falls at t0.
  - The ADC samples at the negedge at t0+0.5.
  - Bit 11 is captured at posedge t0+2; bit k is captured at t0+13−k; bit 0 at t0+13.
- At posedge t0+14:
  - `ad_cs` goes to 1;
  - all four output words load simultaneously;
  - `sample_valid` = 1 for the cycle after t0+14.
- Latency from ADC sample instant to valid: 13.5 cycles.
- Back-to-back with defaults: `ad_cs` pattern is 14 low, 2 high, repeating. `sample_valid` pulses every 16 cycles.
- First CONV after reset: `enable` must be sampled high at a posedge, so the earliest `ad_cs` fall is the first posedge after `reset` deasserts.
- `busy` = 1 from t0 until the posedge that returns the block to IDLE.

## Structure
- `launcher_pkg` holds:
  - `ADC_BITS` = 12;
  - `CONV_CYCLES` = 14;
  - `adc_state_t` {IDLE, CONV, QUIET};
  - `adc_sample_t` packed struct {vcap, icap, vout, iout}, to be reused by the current-loop block.
- One sub-module, `adc_lane_deser`: a 12-bit shift register with a shift enable, instantiated four times.

## Test plan
- Reset: hold `reset` with `enable` = 1 → `ad_cs` = 1, all words 0, no `sample_valid`.
- Single conversion: ADC model at vcap = 320 V, icap = 0, vout = 20 V, iout = 2 A → `vcap` = 0xA00, `icap` = 0x000, `vout` = 0x0A0, `iout` = 0x200, plus one `sample_valid` at t0+14.
- Continuous run with defaults for 1000 cycles → `ad_cs` 14 low / 2 high every period, 62 or 63 valid pulses, each at 16-cycle spacing.
- `enable` dropped at t0+5 → the frame still completes with correct data, `ad_cs` then stays high, `busy` clears at t0+16.
- `reset` pulsed at t0+7 → `ad_cs` high immediately, no `sample_valid`; the next conversion after re-enable returns correct data.
- `CONV_PERIOD` = 10 → measured period 16, `ad_cs` high for at least 2 cycles between every pair of frames.
